// File: rtl/commit_unit_tpu_if.sv
// Bus between the commit unit and the issue/execution side: issue requests,
// two completion lanes, and commit/occupancy status back to the hazard stage.
interface commit_unit_tpu_if #(
  parameter int unsigned WIDTH_BUFF = 4
);
  logic                  I_Req_Issue;
  logic [WIDTH_BUFF-1:0] I_Issue_No;
  logic                  I_Done_A;
  logic [WIDTH_BUFF-1:0] I_Done_No_A;
  logic                  I_Done_B;
  logic [WIDTH_BUFF-1:0] I_Done_No_B;
  logic                  O_Req_Commit;
  logic [WIDTH_BUFF-1:0] O_Commit_No;
  logic                  O_Full;
  logic                  O_Empty;
  logic [WIDTH_BUFF:0]   O_Num;
  logic                  O_Err;

  // Issue/execution side drives requests and completions.
  modport master (
    output I_Req_Issue, I_Issue_No, I_Done_A, I_Done_No_A, I_Done_B, I_Done_No_B,
    input  O_Req_Commit, O_Commit_No, O_Full, O_Empty, O_Num, O_Err
  );

  // Commit unit side.
  modport slave (
    input  I_Req_Issue, I_Issue_No, I_Done_A, I_Done_No_A, I_Done_B, I_Done_No_B,
    output O_Req_Commit, O_Commit_No, O_Full, O_Empty, O_Num, O_Err
  );
endinterface

// File: rtl/commit_unit_tpu.sv
// In-order commit stage: tracks issued entries by issue number, accepts
// out-of-order completions from two lanes and retires the head entry once it
// is done, at most one per cycle. Protocol violations raise a sticky error.
module commit_unit_tpu #(
  parameter int unsigned DEPTH_BUFF = 16,
  parameter int unsigned WIDTH_BUFF = $clog2(DEPTH_BUFF)
) (
  input  logic              clock,
  input  logic              reset,
  commit_unit_tpu_if.slave  bus
);

  logic [DEPTH_BUFF-1:0] v_q, v_d;
  logic [DEPTH_BUFF-1:0] d_q, d_d;
  logic [WIDTH_BUFF-1:0] h_q, h_d;
  logic [WIDTH_BUFF:0]   n_q, n_d;
  logic [WIDTH_BUFF-1:0] commit_no_q, commit_no_d;
  logic                  commit_q;
  logic                  full_q;
  logic                  empty_q;
  logic                  err_q, err_d;

  logic commit_fire;
  logic issue_ok, issue_err;
  logic done_a_ok, done_a_err;
  logic done_b_ok, done_b_err;

  // Decisions are taken on registered state only, so an entry issued this
  // cycle is not yet valid for completion, and an issue to the committing head
  // still sees it valid.
  always_comb begin
    commit_fire = v_q[h_q] & d_q[h_q];
    issue_ok    = bus.I_Req_Issue & ~v_q[bus.I_Issue_No];
    issue_err   = bus.I_Req_Issue &  v_q[bus.I_Issue_No];
    done_a_ok   = bus.I_Done_A    &  v_q[bus.I_Done_No_A];
    done_a_err  = bus.I_Done_A    & ~v_q[bus.I_Done_No_A];
    done_b_ok   = bus.I_Done_B    &  v_q[bus.I_Done_No_B];
    done_b_err  = bus.I_Done_B    & ~v_q[bus.I_Done_No_B];
  end

  // Next-state for entry bits, head, count, commit number and error.
  always_comb begin
    v_d         = v_q;
    d_d         = d_q;
    h_d         = h_q;
    commit_no_d = commit_no_q;
    err_d       = err_q | issue_err | done_a_err | done_b_err;

    if (done_a_ok) d_d[bus.I_Done_No_A] = 1'b1;
    if (done_b_ok) d_d[bus.I_Done_No_B] = 1'b1;
    if (issue_ok) begin
      v_d[bus.I_Issue_No] = 1'b1;
      d_d[bus.I_Issue_No] = 1'b0;
    end
    // Commit clear goes last so a late duplicate completion cannot revive it.
    if (commit_fire) begin
      v_d[h_q]    = 1'b0;
      d_d[h_q]    = 1'b0;
      h_d         = h_q + 1'b1;
      commit_no_d = h_q;
    end

    unique case ({issue_ok, commit_fire})
      2'b10:   n_d = n_q + 1'b1;
      2'b01:   n_d = n_q - 1'b1;
      default: n_d = n_q;
    endcase
  end

  // State and registered outputs; reset discards all in-flight entries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q         <= '0;
      d_q         <= '0;
      h_q         <= '0;
      n_q         <= '0;
      commit_q    <= 1'b0;
      commit_no_q <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      v_q         <= v_d;
      d_q         <= d_d;
      h_q         <= h_d;
      n_q         <= n_d;
      commit_q    <= commit_fire;
      commit_no_q <= commit_no_d;
      full_q      <= (n_d == (WIDTH_BUFF + 1)'(DEPTH_BUFF));
      empty_q     <= (n_d == '0);
      err_q       <= err_d;
    end
  end

  assign bus.O_Req_Commit = commit_q;
  assign bus.O_Commit_No  = commit_no_q;
  assign bus.O_Full       = full_q;
  assign bus.O_Empty      = empty_q;
  assign bus.O_Num        = n_q;
  assign bus.O_Err        = err_q;

endmodule

// File: tb/tb_commit_unit_tpu.sv
// Self-checking bench for commit_unit_tpu: expected commit numbers are queued
// as completions are driven and popped by a monitor when commits appear.
module tb_commit_unit_tpu;
  localparam int D = 16;
  localparam int W = 4;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   n_commits;
  int   sb[$];
  int   commit_cyc[$];

  commit_unit_tpu_if #(.WIDTH_BUFF(W)) bus ();

  commit_unit_tpu #(.DEPTH_BUFF(D), .WIDTH_BUFF(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic clear_inputs();
    bus.I_Req_Issue = 1'b0;
    bus.I_Issue_No  = '0;
    bus.I_Done_A    = 1'b0;
    bus.I_Done_No_A = '0;
    bus.I_Done_B    = 1'b0;
    bus.I_Done_No_B = '0;
  endtask

  // Present one cycle of stimulus; returns 1 time unit after the sampling edge.
  task automatic drive(input logic iss, input int ino, input logic da, input int na,
                       input logic db, input int nb);
    bus.I_Req_Issue = iss;
    bus.I_Issue_No  = W'(ino);
    bus.I_Done_A    = da;
    bus.I_Done_No_A = W'(na);
    bus.I_Done_B    = db;
    bus.I_Done_No_B = W'(nb);
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #1 reset = 1'b0;
    #1;
    chk("reset_req_commit", int'(bus.O_Req_Commit), 0);
    chk("reset_commit_no", int'(bus.O_Commit_No), 0);
    chk("reset_full", int'(bus.O_Full), 0);
    chk("reset_empty", int'(bus.O_Empty), 1);
    chk("reset_num", int'(bus.O_Num), 0);
    chk("reset_err", int'(bus.O_Err), 0);
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_in_order();
    int t;
    for (int i = 0; i < 3; i++) drive(1'b1, i, 1'b0, 0, 1'b0, 0);
    chk("inord_num3", int'(bus.O_Num), 3);
    chk("inord_not_empty", int'(bus.O_Empty), 0);
    drive(1'b0, 0, 1'b1, 2, 1'b0, 0);
    commit_cyc.delete();
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(2);
    t = cyc;
    drive(1'b0, 0, 1'b0, 0, 1'b1, 0);
    drive(1'b0, 0, 1'b1, 1, 1'b0, 0);
    idle(4);
    chk("inord_commits", commit_cyc.size(), 3);
    if (commit_cyc.size() > 0) chk("inord_latency", commit_cyc[0], t + 2);
    chk("inord_num0", int'(bus.O_Num), 0);
    chk("inord_empty", int'(bus.O_Empty), 1);
    chk("inord_sb_drained", sb.size(), 0);
  endtask

  task automatic test_full();
    for (int i = 0; i < D; i++) drive(1'b1, i, 1'b0, 0, 1'b0, 0);
    chk("full_flag", int'(bus.O_Full), 1);
    chk("full_num", int'(bus.O_Num), 16);
    chk("full_err_before", int'(bus.O_Err), 0);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 0);
    chk("full_reissue_err", int'(bus.O_Err), 1);
    chk("full_num_held", int'(bus.O_Num), 16);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < D - 1; i++) drive(1'b1, i, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < D - 1; i++) begin
      sb.push_back(i);
      drive(1'b0, 0, 1'b1, i, 1'b0, 0);
    end
    idle(4);
    chk("wrap_drained", int'(bus.O_Num), 0);
    drive(1'b1, 15, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < D - 1; i++) drive(1'b1, i, 1'b0, 0, 1'b0, 0);
    chk("wrap_full", int'(bus.O_Full), 1);
    chk("wrap_err_before", int'(bus.O_Err), 0);
    sb.push_back(15);
    drive(1'b0, 0, 1'b1, 15, 1'b0, 0);
    // Head 15 commits at the next edge; reissue in that cycle must be rejected.
    drive(1'b1, 15, 1'b0, 0, 1'b0, 0);
    chk("wrap_reissue_rejected_err", int'(bus.O_Err), 1);
    chk("wrap_num_after_commit", int'(bus.O_Num), 15);
    drive(1'b1, 15, 1'b0, 0, 1'b0, 0);
    chk("wrap_reissue_accepted", int'(bus.O_Num), 16);
    sb.push_back(0);
    drive(1'b0, 0, 1'b1, 0, 1'b0, 0);
    idle(3);
    chk("wrap_head0_num", int'(bus.O_Num), 15);
    chk("wrap_sb_drained", sb.size(), 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, i, 1'b0, 0, 1'b0, 0);
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(2);
    drive(1'b0, 0, 1'b1, 0, 1'b1, 1);
    drive(1'b0, 0, 1'b1, 2, 1'b0, 0);
    idle(4);
    commit_cyc.delete();
    sb.push_back(3);
    sb.push_back(4);
    drive(1'b0, 0, 1'b1, 3, 1'b1, 4);
    idle(4);
    chk("b2b_commits", commit_cyc.size(), 2);
    if (commit_cyc.size() == 2) chk("b2b_consecutive", commit_cyc[1] - commit_cyc[0], 1);
    chk("b2b_empty", int'(bus.O_Empty), 1);
    chk("b2b_sb_drained", sb.size(), 0);
  endtask

  task automatic test_errors();
    int c0;
    c0 = n_commits;
    drive(1'b1, 5, 1'b0, 0, 1'b0, 0);
    sb.push_back(5);
    drive(1'b0, 0, 1'b1, 5, 1'b1, 5);
    idle(4);
    chk("dual_done_single_commit", n_commits - c0, 1);
    chk("dual_done_no_err", int'(bus.O_Err), 0);
    drive(1'b0, 0, 1'b1, 7, 1'b0, 0);
    idle(3);
    chk("bad_done_err", int'(bus.O_Err), 1);
    chk("bad_done_no_commit", n_commits - c0, 1);
    chk("bad_done_num", int'(bus.O_Num), 0);
    chk("bad_done_empty", int'(bus.O_Empty), 1);
  endtask

  task automatic test_async_reset();
    int c0;
    for (int i = 6; i < 11; i++) drive(1'b1, i, 1'b0, 0, 1'b0, 0);
    chk("ares_num5", int'(bus.O_Num), 5);
    drive(1'b0, 0, 1'b1, 7, 1'b0, 0);
    c0 = n_commits;
    #2 reset = 1'b0;
    #1;
    chk("ares_num", int'(bus.O_Num), 0);
    chk("ares_empty", int'(bus.O_Empty), 1);
    chk("ares_err", int'(bus.O_Err), 0);
    chk("ares_commit_no", int'(bus.O_Commit_No), 0);
    chk("ares_req", int'(bus.O_Req_Commit), 0);
    idle(2);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("ares_no_commits", n_commits - c0, 0);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 0);
    chk("ares_issue0_num", int'(bus.O_Num), 1);
    chk("ares_issue0_err", int'(bus.O_Err), 0);
    sb.push_back(0);
    drive(1'b0, 0, 1'b1, 0, 1'b0, 0);
    idle(3);
    chk("ares_drain_num", int'(bus.O_Num), 0);
    chk("ares_sb_drained", sb.size(), 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    n_commits = 0;
    reset     = 1'b1;
    clear_inputs();
    // Commit monitor: every pulse must match the oldest expected number.
    fork
      forever begin
        @(negedge clock);
        if (reset && bus.O_Req_Commit) begin
          n_commits++;
          commit_cyc.push_back(cyc);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected: got commit no %0d, required no commit",
                     bus.O_Commit_No);
          end else begin
            int exp;
            exp = sb.pop_front();
            if (int'(bus.O_Commit_No) !== exp) begin
              errors++;
              $display("FAIL commit_no: got %0d, required %0d", bus.O_Commit_No, exp);
            end
          end
        end
      end
    join_none
    test_reset();
    test_in_order();
    test_full();
    test_wrap();
    test_back_to_back();
    test_errors();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_unit_tpu.md
Name: commit_unit_tpu

Overview:
- In-order commit stage for the TPU scalar-unit backend. It sits downstream of the hazard-check and issue stage and next to the execution lanes.
- Records every issued instruction by its issue number and accepts out-of-order completions from two execution write-back ports.
- Retires entries strictly in issue order, one per cycle. Each retirement is returned to the hazard-check stage as a commit request plus commit number, which frees that stage's hazard-table entry.

Parameters:
- DEPTH_BUFF, 16, number of in-flight entries; must match the hazard-check ring buffer depth; power of two.
- WIDTH_BUFF, $clog2(DEPTH_BUFF), width of issue and commit numbers.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- I_Req_Issue  in  1  instruction issued this cycle.
- I_Issue_No  in  WIDTH_BUFF  issue number of that instruction (hazard-stage read pointer).
- I_Done_A  in  1  completion pulse, lane A.
- I_Done_No_A  in  WIDTH_BUFF  issue number completed on lane A.
- I_Done_B  in  1  completion pulse, lane B.
- I_Done_No_B  in  WIDTH_BUFF  issue number completed on lane B.
- O_Req_Commit  out  1  commit request to the hazard-check stage, one-cycle pulse.
- O_Commit_No  out  WIDTH_BUFF  issue number being committed.
- O_Full  out  1  all DEPTH_BUFF entries in flight.
- O_Empty  out  1  no entries in flight.
- O_Num  out  WIDTH_BUFF+1  in-flight entry count.
- O_Err  out  1  sticky protocol-error flag.

Behaviour:
- State:
  - Per-entry bits V (issued) and D (done).
  - Head pointer H (WIDTH_BUFF bits).
  - Count N (WIDTH_BUFF+1 bits).
- Reset (reset==0, asynchronous):
  - All V and D cleared; H=0; N=0; O_Err=0.
  - Outputs: O_Req_Commit=0, O_Commit_No=0, O_Full=0, O_Empty=1, O_Num=0.
  - When reset is asserted mid-operation, all in-flight entries are discarded with no commit pulses.
- Issue:
  - When I_Req_Issue=1 and V[I_Issue_No]=0, the next edge sets V=1 and D=0.
  - When I_Req_Issue=1 and V[I_Issue_No]=1, the issue is ignored and O_Err is set. This includes the case O_Full=1.
- Completion:
  - I_Done_x on an entry with V=1 sets D=1 at the next edge.
  - I_Done_x on an entry with V=0 (including an entry issued in the same cycle) is ignored and sets O_Err.
  - A and B both naming the same valid entry in one cycle sets D once, with no error.
  - A repeat completion on an entry that already has D=1 is harmless.
- Commit decision (combinational on registered state):
  - Commit fires when V[H]=1 and D[H]=1.
  - At the next edge: V[H] and D[H] cleared; H=H+1 (wraps DEPTH_BUFF-1 -> 0); O_Req_Commit<=1; O_Commit_No<=H (old value).
  - Otherwise O_Req_Commit<=0 and O_Commit_No holds its value.
- Throughput and latency:
  - At most one commit per cycle.
  - A completion pulse in cycle t produces O_Req_Commit in cycle t+2 if that entry is at the head.
  - Back-to-back commits are possible when consecutive head entries are done.
- Count:
  - N increments on an accepted issue and decrements on a commit.
  - Both in the same cycle leave N unchanged.
  - O_Full=(N==DEPTH_BUFF), O_Empty=(N==0), O_Num=N. All are registered and consistent with N.
- Same-cycle interactions:
  - An issue to entry H in the same cycle H commits sees V[H]=1 at sample time, so it is an error and is ignored.
  - Issue and commit to different entries proceed independently.
- O_Err clears only on reset.

Test Plan:
- Reset, then issue No 0,1,2 on consecutive cycles; Done_A No 2, then Done_B No 0, then Done_A No 1 -> commits No 0,1,2 in order; the first O_Req_Commit occurs 2 cycles after Done_B No 0; O_Num returns to 0 and O_Empty=1.
- Issue 16 entries with no completions -> O_Full=1, O_Num=16; issue No 0 again -> O_Err=1 and O_Num stays 16.
- With entries 0..15 issued and H=15: complete 15, then issue No 15 -> after the commit H wraps to 0; the reissue of No 15 is accepted only after its commit edge.
- With entries 3 and 4 at the head, Done_A No 3 and Done_B No 4 in the same cycle -> O_Req_Commit high for two consecutive cycles with O_Commit_No 3 then 4.
- Done_A on an unissued No 7 -> O_Err=1, no commit, state otherwise unchanged; Done_A and Done_B both on valid No 5 -> single commit, O_Err unchanged.
- Drop reset with 5 entries in flight -> outputs take reset values immediately with no clock edge needed; no commit pulses; issue No 0 accepted after release.
